// File: rtl/alu_pkg.sv
// alu_pkg: function select and result code constants shared by the ALU compare slot
package alu_pkg;
    localparam logic [2:0] CMP_NOP     = 3'd0;
    localparam logic [2:0] CMP_EQ      = 3'd1;
    localparam logic [2:0] CMP_GT      = 3'd2;
    localparam logic [2:0] CMP_LT      = 3'd3;
    localparam logic [2:0] CMP_MIN     = 3'd4;
    localparam logic [2:0] CMP_MAX     = 3'd5;
    localparam logic [2:0] CMP_ACC_MIN = 3'd6;
    localparam logic [2:0] CMP_ACC_MAX = 3'd7;
    localparam logic [1:0] CODE_EQ     = 2'd1;
    localparam logic [1:0] CODE_GT     = 2'd2;
    localparam logic [1:0] CODE_LT     = 2'd3;
endpackage

// File: rtl/cmp_core.sv
// cmp_core: combinational signed/unsigned three-way compare of a against b
module cmp_core #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic         eq,
    output logic         gt,
    output logic         lt
);
    assign eq = a == b;
    assign gt = is_signed ? $signed(a) > $signed(b) : a > b;
    assign lt = is_signed ? $signed(a) < $signed(b) : a < b;
endmodule

// File: rtl/cmp_unit_seq.sv
// cmp_unit_seq: compare/min/max unit with running accumulator, saturating hit counter
// and an optional second output register
module cmp_unit_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_WIDTH   = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [2:0]            cmp_fun,
    input  logic                  cmp_en,
    input  logic                  cmp_signed,
    input  logic                  acc_clr,
    output logic [DATA_WIDTH-1:0] cmp_out,
    output logic                  cmp_flag,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic                  acc_valid
);
    logic eq, gt, lt, a_eq, a_gt, a_lt;
    logic acc_op, acc_empty, hit;
    logic [DATA_WIDTH-1:0] acc, new_acc, res, s1_out;
    logic s1_flag;

    cmp_core #(.W(DATA_WIDTH)) u_ab (.a(in1), .b(in2), .is_signed(cmp_signed), .eq(eq), .gt(gt), .lt(lt));
    cmp_core #(.W(DATA_WIDTH)) u_acc (.a(in1), .b(acc), .is_signed(cmp_signed), .eq(a_eq), .gt(a_gt), .lt(a_lt));

    assign acc_op    = cmp_en && cmp_fun[2] && cmp_fun[1];
    // a same-cycle clear makes the op start from an empty accumulator
    assign acc_empty = !acc_valid || acc_clr;
    assign new_acc   = (acc_empty || (cmp_fun[0] ? (a_gt || a_eq) : (a_lt || a_eq))) ? in1 : acc;
    assign hit       = cmp_en && ((cmp_fun == CMP_EQ && eq) || (cmp_fun == CMP_GT && gt) ||
                                  (cmp_fun == CMP_LT && lt));

    always_comb begin
        res = '0;
        case (cmp_fun)
            CMP_EQ:      res = eq ? DATA_WIDTH'(CODE_EQ) : '0;
            CMP_GT:      res = gt ? DATA_WIDTH'(CODE_GT) : '0;
            CMP_LT:      res = lt ? DATA_WIDTH'(CODE_LT) : '0;
            CMP_MIN:     res = gt ? in2 : in1;
            CMP_MAX:     res = lt ? in2 : in1;
            CMP_ACC_MIN,
            CMP_ACC_MAX: res = new_acc;
            default:     res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_out    <= '0;
            s1_flag   <= 1'b0;
            acc       <= '0;
            acc_valid <= 1'b0;
            hit_cnt   <= '0;
        end else begin
            s1_out  <= cmp_en ? res : '0;
            s1_flag <= cmp_en;
            if (acc_op) begin
                acc       <= new_acc;
                acc_valid <= 1'b1;
            end else if (acc_clr) begin
                acc       <= '0;
                acc_valid <= 1'b0;
            end
            if (hit && !(&hit_cnt))
                hit_cnt <= hit_cnt + 1'b1;
        end
    end

    generate
        if (PIPE_STAGES == 1) begin : g_pipe1
            assign cmp_out  = s1_out;
            assign cmp_flag = s1_flag;
        end else if (PIPE_STAGES == 2) begin : g_pipe2
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmp_out  <= '0;
                    cmp_flag <= 1'b0;
                end else begin
                    cmp_out  <= s1_out;
                    cmp_flag <= s1_flag;
                end
            end
        end else begin : g_bad
            $error("cmp_unit_seq: PIPE_STAGES must be 1 or 2");
        end
    endgenerate
endmodule

// File: doc/cmp_unit_seq.md
Name: cmp_unit_seq

Overview:
- Parametrised successor to the ALU's 2-bit compare unit.
- Adds signed/unsigned compare, MIN/MAX select, running min/max accumulation across cycles, and a saturating hit counter.
- Optional extra output pipeline stage.
- Sits in the ALU compare slot, fed by the operand bus and decoded function field; results return to the ALU output mux.

Parameters:
- DATA_WIDTH, 16, operand and result width (>=2).
- CNT_WIDTH, 8, width of the saturating hit counter.
- PIPE_STAGES, 1, result latency in cycles; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in1  input  DATA_WIDTH  operand A.
- in2  input  DATA_WIDTH  operand B.
- cmp_fun  input  3  function select (encoding below).
- cmp_en  input  1  operation valid this cycle.
- cmp_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- acc_clr  input  1  invalidate the running accumulator.
- cmp_out  output  DATA_WIDTH  registered result.
- cmp_flag  output  1  result valid, aligned with cmp_out.
- hit_cnt  output  CNT_WIDTH  saturating count of true EQ/GT/LT results.
- acc_valid  output  1  accumulator holds at least one sample.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cmp_out=0, cmp_flag=0, hit_cnt=0, acc_valid=0.
  - Internal acc register and all pipeline registers = 0.
  - Takes effect mid-operation; in-flight results are discarded.
- Function encoding (all compares honour cmp_signed):
  - 000 NOP: out 0, flag 1.
  - 001 EQ: out 1 if in1==in2, else 0.
  - 010 GT: out 2 if in1>in2, else 0.
  - 011 LT: out 3 if in1<in2, else 0.
  - 100 MIN: out = smaller of in1, in2; on tie, in1.
  - 101 MAX: out = larger of in1, in2; on tie, in1.
  - 110 ACC_MIN: new_acc = acc_valid ? min(acc, in1) : in1; out = new_acc; acc<=new_acc; acc_valid<=1. in2 is ignored.
  - 111 ACC_MAX: same as ACC_MIN with max.
- Codes 1/2/3 are zero-extended to DATA_WIDTH.
- cmp_en=1: cmp_flag=1 after the configured latency, for every function.
- cmp_en=0: out 0, flag 0 at the same latency. acc, acc_valid and hit_cnt hold.
- Latency:
  - PIPE_STAGES=1: operands sampled at edge N, result visible after edge N (one cycle).
  - PIPE_STAGES=2: one additional register on cmp_out/cmp_flag only.
  - acc, acc_valid and hit_cnt always update at stage 1; accumulator feedback is never pipelined.
  - Back-to-back operations are accepted every cycle; no stalls.
- acc_clr:
  - acc_clr=1 with no ACC op that cycle: acc_valid<=0, acc<=0.
  - acc_clr=1 with cmp_en=1 and an ACC op in the same cycle: the op treats the accumulator as empty; acc<=in1, acc_valid<=1.
- Switching between ACC_MIN and ACC_MAX without clear continues from the current acc value.
- Changing cmp_signed between ACC ops is legal; each step compares with the current mode.
- hit_cnt:
  - Increments by 1 on each cmp_en cycle where EQ/GT/LT produces a non-zero code.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - Cleared only by reset; acc_clr does not clear it.
- Signed compare: sign-aware on the full DATA_WIDTH; no overflow or wrap cases exist.
- Unknown PIPE_STAGES: elaboration error.

Decomposition:
- Shared package (alu_pkg): cmp_fun localparams CMP_NOP, CMP_EQ, CMP_GT, CMP_LT, CMP_MIN, CMP_MAX, CMP_ACC_MIN, CMP_ACC_MAX; result code constants CODE_EQ=1, CODE_GT=2, CODE_LT=3.
- One natural sub-module: cmp_core.
  - Combinational.
  - Inputs: a, b, signed.
  - Outputs: eq, gt, lt.
  - Instantiated twice: in1 vs in2, and in1 vs acc.

Test Plan (DATA_WIDTH=8 unless noted):
1. GT in1=0x80, in2=0x01: cmp_signed=1 -> out 0x00, flag 1; cmp_signed=0 -> out 0x02; hit_cnt increments only in the unsigned case.
2. MIN/MAX in1=0xFE, in2=0x03, signed -> MIN 0xFE, MAX 0x03; same operands unsigned -> MIN 0x03, MAX 0xFE; tie in1=in2=0x05 -> 0x05.
3. Accumulator:
   - acc_clr, then ACC_MAX in1=5,9,3 back-to-back -> outs 5,9,9; acc_valid=1 from the first result.
   - acc_clr together with ACC_MIN in1=2 -> out 2.
   - acc_clr alone -> acc_valid 0.
4. cmp_en=0 for 3 cycles between ACC_MAX ops -> out 0, flag 0 during the gap; the accumulator resumes with the same value afterwards.
5. CNT_WIDTH=2, five consecutive EQ hits -> hit_cnt 1,2,3,3,3; assert rst_n mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
6. PIPE_STAGES=2, EQ 7==7 at edge N -> out 1, flag 1 after edge N+1. Sustained random ops must match a reference model delayed by 2 cycles.
